// File: rtl/vector_issue_sequencer_pkg.sv
// Shared definitions for the vector issue sequencer: element-width codes,
// FSM state encoding and small SEW decode helpers.
package vector_issue_sequencer_pkg;

    // Element width codes as carried on cur_vsew
    typedef enum logic [2:0] {
        ONE_BYTE   = 3'd0,
        TWO_BYTE   = 3'd1,
        FOUR_BYTE  = 3'd2,
        EIGHT_BYTE = 3'd3
    } vsew_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // log2 of the element width in bits; unknown codes behave as 64-bit
    function automatic logic [31:0] sew_log2(input logic [2:0] vsew);
        logic [31:0] r;
        case (vsew)
            ONE_BYTE:  r = 32'd3;
            TWO_BYTE:  r = 32'd4;
            FOUR_BYTE: r = 32'd5;
            default:   r = 32'd6;
        endcase
        return r;
    endfunction

    // Low-SEW-bits mask for a 64-bit element; unknown codes behave as 64-bit
    function automatic logic [63:0] sew_mask(input logic [2:0] vsew);
        logic [63:0] r;
        case (vsew)
            ONE_BYTE:  r = 64'h0000_0000_0000_00FF;
            TWO_BYTE:  r = 64'h0000_0000_0000_FFFF;
            FOUR_BYTE: r = 64'h0000_0000_FFFF_FFFF;
            default:   r = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vector_elem_slicer.sv
// Extracts element idx of width SEW from a packed vector register and
// zero-extends it to the lane operand width. Indices past the end of the
// register yield zero rather than X.
module vector_elem_slicer
    import vector_issue_sequencer_pkg::*;
#(
    parameter int LONGEST_LEN = 64,
    parameter int VECTOR_SIZE = 8,
    parameter int IDX_W       = 7
) (
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vec_i,
    input  logic [IDX_W-1:0]                   idx_i,
    input  logic [2:0]                         vsew_i,
    output logic [LONGEST_LEN-1:0]             elem_o
);

    localparam int TOTAL = VECTOR_SIZE * LONGEST_LEN;

    logic [31:0]      shamt;
    logic [TOTAL-1:0] shifted;

    // Barrel-shift the element down to bit 0 and keep only its SEW bits
    always_comb begin
        shamt   = 32'(idx_i) << sew_log2(vsew_i);
        shifted = vec_i >> shamt;
        elem_o  = shifted[LONGEST_LEN-1:0] & LONGEST_LEN'(sew_mask(vsew_i));
    end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Vector issue sequencer: captures one vector instruction's operands, feeds
// LANE_SIZE elements per cycle to external ALU lanes, and merges the lane
// results into the destination register (mask- and tail-undisturbed).
module vector_issue_sequencer
    import vector_issue_sequencer_pkg::*;
#(
    parameter int LONGEST_LEN = 64,
    parameter int VECTOR_SIZE = 8,
    parameter int LANE_SIZE   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               ready,
    input  logic [2:0]                         cur_vsew,
    input  logic [6:0]                         vl,
    input  logic                               vm,
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs1_data,
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs2_data,
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vd_old,
    input  logic [63:0]                        v0_mask,
    output logic [LANE_SIZE-1:0]               lane_valid,
    output logic [LANE_SIZE*LONGEST_LEN-1:0]   lane_vs1,
    output logic [LANE_SIZE*LONGEST_LEN-1:0]   lane_vs2,
    output logic [LANE_SIZE-1:0]               lane_mask,
    output logic                               lane_vm,
    input  logic [LANE_SIZE*LONGEST_LEN-1:0]   lane_result,
    output logic [VECTOR_SIZE*LONGEST_LEN-1:0] vd_data,
    output logic                               done
);

    localparam int TOTAL     = VECTOR_SIZE * LONGEST_LEN;
    // Element count at the narrowest width (8-bit elements)
    localparam int MAX_ELEMS = VECTOR_SIZE * 8;
    // Wide enough for base + lane offset without wrapping
    localparam int IDX_W     = $clog2(MAX_ELEMS + LANE_SIZE + 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  base_q, base_d;
    logic [IDX_W-1:0]  evl_q, evl_d;
    logic [2:0]        vsew_q, vsew_d;
    logic              vm_q, vm_d;
    logic [TOTAL-1:0]  vs1_q, vs1_d;
    logic [TOTAL-1:0]  vs2_q, vs2_d;
    logic [63:0]       mask_q, mask_d;
    logic [TOTAL-1:0]  vd_q, vd_d;

    logic                   issue;
    logic [31:0]            vlmax_in;
    logic [31:0]            evl_in_w;
    logic [IDX_W-1:0]       evl_in;
    logic [LONGEST_LEN-1:0] elem_mask;

    logic [LANE_SIZE-1:0]   wr_en;
    logic [TOTAL-1:0]       wr_clr  [LANE_SIZE];
    logic [TOTAL-1:0]       wr_data [LANE_SIZE];

    assign issue     = (state_q == ISSUE);
    assign elem_mask = LONGEST_LEN'(sew_mask(vsew_q));

    // Effective vector length of the incoming instruction, clamped to VLMAX
    always_comb begin
        vlmax_in = (32'(VECTOR_SIZE) * 32'd64) >> sew_log2(cur_vsew);
        evl_in_w = (32'(vl) > vlmax_in) ? vlmax_in : 32'(vl);
        evl_in   = IDX_W'(evl_in_w);
    end

    // Per-lane operand slicing, lane outputs and result write-back terms
    generate
        for (genvar gi = 0; gi < LANE_SIZE; gi++) begin : g_lane
            logic [IDX_W-1:0]       idx;
            logic [31:0]            shamt;
            logic                   in_range;
            logic                   mask_bit;
            logic [LONGEST_LEN-1:0] op1;
            logic [LONGEST_LEN-1:0] op2;
            logic [LONGEST_LEN-1:0] res;

            assign idx      = base_q + IDX_W'(gi);
            assign shamt    = 32'(idx) << sew_log2(vsew_q);
            assign in_range = (idx < evl_q);
            assign mask_bit = (32'(idx) < 32'd64) ? mask_q[6'(idx)] : 1'b0;
            assign res      = lane_result[gi*LONGEST_LEN +: LONGEST_LEN];

            vector_elem_slicer #(
                .LONGEST_LEN (LONGEST_LEN),
                .VECTOR_SIZE (VECTOR_SIZE),
                .IDX_W       (IDX_W)
            ) u_slice_vs1 (
                .vec_i  (vs1_q),
                .idx_i  (idx),
                .vsew_i (vsew_q),
                .elem_o (op1)
            );

            vector_elem_slicer #(
                .LONGEST_LEN (LONGEST_LEN),
                .VECTOR_SIZE (VECTOR_SIZE),
                .IDX_W       (IDX_W)
            ) u_slice_vs2 (
                .vec_i  (vs2_q),
                .idx_i  (idx),
                .vsew_i (vsew_q),
                .elem_o (op2)
            );

            // Lane outputs are forced quiet outside ISSUE
            assign lane_valid[gi] = issue && in_range;
            assign lane_mask[gi]  = issue && mask_bit;
            assign lane_vs1[gi*LONGEST_LEN +: LONGEST_LEN] = issue ? op1 : '0;
            assign lane_vs2[gi*LONGEST_LEN +: LONGEST_LEN] = issue ? op2 : '0;

            // Active, unmasked elements overwrite their SEW-wide slot only
            assign wr_en[gi]   = issue && in_range && (mask_bit || !vm_q);
            assign wr_clr[gi]  = TOTAL'(elem_mask) << shamt;
            assign wr_data[gi] = TOTAL'(res & elem_mask) << shamt;
        end
    endgenerate

    // Next-state: instruction capture, element stepping and result merge
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        evl_d   = evl_q;
        vsew_d  = vsew_q;
        vm_d    = vm_q;
        vs1_d   = vs1_q;
        vs2_d   = vs2_q;
        mask_d  = mask_q;
        vd_d    = vd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vsew_d  = cur_vsew;
                    vm_d    = vm;
                    vs1_d   = vs1_data;
                    vs2_d   = vs2_data;
                    mask_d  = v0_mask;
                    vd_d    = vd_old;
                    base_d  = '0;
                    evl_d   = evl_in;
                    state_d = (evl_in == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                for (int k = 0; k < LANE_SIZE; k++) begin
                    if (wr_en[k]) begin
                        vd_d = (vd_d & ~wr_clr[k]) | wr_data[k];
                    end
                end
                base_d = base_q + IDX_W'(LANE_SIZE);
                if (base_d >= evl_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            evl_q   <= '0;
            vsew_q  <= 3'd0;
            vm_q    <= 1'b0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            mask_q  <= '0;
            vd_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            evl_q   <= evl_d;
            vsew_q  <= vsew_d;
            vm_q    <= vm_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            mask_q  <= mask_d;
            vd_q    <= vd_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign lane_vm = vm_q;
    assign vd_data = vd_q;

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed testbench for vector_issue_sequencer with adding ALU lanes.
module tb_vector_issue_sequencer;

    localparam int LEN   = 64;
    localparam int VSZ   = 8;
    localparam int LANES = 2;
    localparam int TOTAL = LEN * VSZ;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   ready;
    logic [2:0]             cur_vsew;
    logic [6:0]             vl;
    logic                   vm;
    logic [TOTAL-1:0]       vs1_data;
    logic [TOTAL-1:0]       vs2_data;
    logic [TOTAL-1:0]       vd_old;
    logic [63:0]            v0_mask;
    logic [LANES-1:0]       lane_valid;
    logic [LANES*LEN-1:0]   lane_vs1;
    logic [LANES*LEN-1:0]   lane_vs2;
    logic [LANES-1:0]       lane_mask;
    logic                   lane_vm;
    logic [LANES*LEN-1:0]   lane_result;
    logic [TOTAL-1:0]       vd_data;
    logic                   done;

    int checks = 0;
    int passes = 0;

    logic [LANES-1:0]     lv_hist [0:255];
    logic [LANES*LEN-1:0] first_vs1;
    logic [LANES*LEN-1:0] first_vs2;
    logic [LANES-1:0]     first_mask;
    logic [TOTAL-1:0]     exp_vd;
    int                   done_cycle;
    int                   issue_cycles;

    vector_issue_sequencer #(
        .LONGEST_LEN (LEN),
        .VECTOR_SIZE (VSZ),
        .LANE_SIZE   (LANES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ready       (ready),
        .cur_vsew    (cur_vsew),
        .vl          (vl),
        .vm          (vm),
        .vs1_data    (vs1_data),
        .vs2_data    (vs2_data),
        .vd_old      (vd_old),
        .v0_mask     (v0_mask),
        .lane_valid  (lane_valid),
        .lane_vs1    (lane_vs1),
        .lane_vs2    (lane_vs2),
        .lane_mask   (lane_mask),
        .lane_vm     (lane_vm),
        .lane_result (lane_result),
        .vd_data     (vd_data),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Adding ALU lanes
    always_comb begin
        lane_result = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_result[k*LEN +: LEN] = lane_vs1[k*LEN +: LEN] + lane_vs2[k*LEN +: LEN];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction and follows it to its done pulse (bounded)
    task automatic run_instr(input logic [2:0] sew, input logic [6:0] vlen,
                             input logic vmb, input logic [63:0] m,
                             input int start_inject_at);
        cur_vsew = sew;
        vl       = vlen;
        vm       = vmb;
        v0_mask  = m;
        start    = 1'b1;
        step();
        start        = 1'b0;
        done_cycle   = 0;
        issue_cycles = 0;
        for (int n = 1; n <= 200; n++) begin
            lv_hist[n] = lane_valid;
            if (n == 1) begin
                first_vs1  = lane_vs1;
                first_vs2  = lane_vs2;
                first_mask = lane_mask;
            end
            if (done === 1'b1) begin
                done_cycle = n;
                break;
            end
            if (ready === 1'b0) issue_cycles++;
            if (n == start_inject_at) start = 1'b1;
            step();
            start = 1'b0;
        end
        $display("txn vsew=%0d vl=%0d vm=%0b done_cycle=%0d issue_cycles=%0d",
                 sew, vlen, vmb, done_cycle, issue_cycles);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        cur_vsew = 3'd3;
        vl       = 7'd8;
        vm       = 1'b0;
        vs1_data = {64{8'h11}};
        vs2_data = {64{8'h22}};
        vd_old   = {64{8'hC3}};
        v0_mask  = '1;
        step();
        step();
        checks++; if (ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", ready); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else passes++;
        checks++; if (lane_valid !== 2'b00) $display("FAIL reset_lane_valid got=%b exp=00", lane_valid); else passes++;
        checks++; if (vd_data !== '0) $display("FAIL reset_vd got=%h exp=0", vd_data); else passes++;
        checks++; if (lane_vs1 !== '0 || lane_mask !== 2'b00) $display("FAIL reset_lane_ops got=%h/%b exp=0", lane_vs1, lane_mask); else passes++;
        rst   = 1'b0;
        start = 1'b0;
        step();
        $display("txn reset released ready=%0b", ready);
    endtask

    task automatic test_eight_byte_add();
        for (int i = 0; i < VSZ; i++) begin
            vs1_data[i*64 +: 64] = 64'(i);
            vs2_data[i*64 +: 64] = 64'd100;
            exp_vd[i*64 +: 64]   = 64'(100 + i);
        end
        vd_old = {64{8'hAA}};
        run_instr(3'd3, 7'd8, 1'b0, 64'h0, 0);
        checks++; if (done_cycle !== 5) $display("FAIL e64_done_cycle got=%0d exp=5", done_cycle); else passes++;
        checks++; if (issue_cycles !== 4) $display("FAIL e64_issue_cycles got=%0d exp=4", issue_cycles); else passes++;
        checks++; if (first_vs1 !== {64'd1, 64'd0}) $display("FAIL e64_first_vs1 got=%h exp=%h", first_vs1, {64'd1, 64'd0}); else passes++;
        checks++; if (first_vs2 !== {64'd100, 64'd100}) $display("FAIL e64_first_vs2 got=%h exp=%h", first_vs2, {64'd100, 64'd100}); else passes++;
        checks++; if (vd_data !== exp_vd) $display("FAIL e64_vd got=%h exp=%h", vd_data, exp_vd); else passes++;
        step();
        checks++; if (done !== 1'b0 || ready !== 1'b1) $display("FAIL e64_done_pulse got done=%0b ready=%0b exp done=0 ready=1", done, ready); else passes++;
    endtask

    task automatic test_one_byte_tail();
        vs1_data = {64{8'h01}};
        vs2_data = {64{8'h01}};
        vd_old   = {64{8'hFF}};
        exp_vd   = {64{8'hFF}};
        for (int i = 0; i < 5; i++) exp_vd[i*8 +: 8] = 8'h02;
        run_instr(3'd0, 7'd5, 1'b0, 64'h0, 0);
        checks++; if (issue_cycles !== 3) $display("FAIL e8_issue_cycles got=%0d exp=3", issue_cycles); else passes++;
        checks++; if (lv_hist[3] !== 2'b01) $display("FAIL e8_lane_valid_3rd got=%b exp=01", lv_hist[3]); else passes++;
        checks++; if (vd_data !== exp_vd) $display("FAIL e8_vd got=%h exp=%h", vd_data, exp_vd); else passes++;
        step();
    endtask

    task automatic test_masked();
        vs1_data = '0;
        vs2_data = '0;
        vs1_data[0*32 +: 32] = 32'h0000_0010;
        vs1_data[1*32 +: 32] = 32'h0000_0011;
        vs1_data[2*32 +: 32] = 32'hFFFF_FFFF;
        vs1_data[3*32 +: 32] = 32'h0000_0013;
        for (int i = 0; i < 4; i++) vs2_data[i*32 +: 32] = 32'h0000_1000;
        vd_old = {64{8'h5A}};
        exp_vd = {64{8'h5A}};
        exp_vd[0*32 +: 32] = 32'h0000_1010;
        exp_vd[2*32 +: 32] = 32'h0000_0FFF;
        run_instr(3'd2, 7'd4, 1'b1, 64'h5, 0);
        checks++; if (first_mask !== 2'b01) $display("FAIL e32_lane_mask got=%b exp=01", first_mask); else passes++;
        checks++; if (issue_cycles !== 2) $display("FAIL e32_issue_cycles got=%0d exp=2", issue_cycles); else passes++;
        checks++; if (vd_data !== exp_vd) $display("FAIL e32_masked_vd got=%h exp=%h", vd_data, exp_vd); else passes++;
        checks++; if (lane_vm !== 1'b1) $display("FAIL e32_lane_vm got=%0b exp=1", lane_vm); else passes++;
        step();
    endtask

    task automatic test_vl_zero();
        vs1_data = {64{8'h01}};
        vs2_data = {64{8'h01}};
        vd_old   = {32{16'hBEEF}};
        run_instr(3'd0, 7'd0, 1'b0, 64'h0, 0);
        checks++; if (done_cycle !== 1) $display("FAIL vl0_done_cycle got=%0d exp=1", done_cycle); else passes++;
        checks++; if (issue_cycles !== 0) $display("FAIL vl0_issue_cycles got=%0d exp=0", issue_cycles); else passes++;
        checks++; if (vd_data !== {32{16'hBEEF}}) $display("FAIL vl0_vd got=%h exp=%h", vd_data, {32{16'hBEEF}}); else passes++;
        step();
    endtask

    task automatic test_clamp_ignore_start();
        for (int i = 0; i < 64; i++) begin
            vs1_data[i*8 +: 8] = 8'(i);
            exp_vd[i*8 +: 8]   = 8'(i + 3);
        end
        vs2_data = {64{8'h03}};
        vd_old   = {64{8'hEE}};
        run_instr(3'd0, 7'd100, 1'b0, 64'h0, 10);
        checks++; if (issue_cycles !== 32) $display("FAIL clamp_issue_cycles got=%0d exp=32", issue_cycles); else passes++;
        checks++; if (done_cycle !== 33) $display("FAIL clamp_done_cycle got=%0d exp=33", done_cycle); else passes++;
        checks++; if (vd_data !== exp_vd) $display("FAIL clamp_vd got=%h exp=%h", vd_data, exp_vd); else passes++;
        step();
    endtask

    task automatic test_two_byte_hold();
        vs1_data = '0;
        vs2_data = '0;
        for (int i = 0; i < 3; i++) begin
            vs1_data[i*16 +: 16] = 16'(16'h0100 * (i + 1));
            vs2_data[i*16 +: 16] = 16'h0001;
        end
        vd_old = {64{8'h77}};
        exp_vd = {64{8'h77}};
        exp_vd[0 +: 16]  = 16'h0101;
        exp_vd[16 +: 16] = 16'h0201;
        exp_vd[32 +: 16] = 16'h0301;
        run_instr(3'd1, 7'd3, 1'b0, 64'h0, 0);
        checks++; if (done_cycle !== 3) $display("FAIL e16_done_cycle got=%0d exp=3", done_cycle); else passes++;
        checks++; if (vd_data !== exp_vd) $display("FAIL e16_vd got=%h exp=%h", vd_data, exp_vd); else passes++;
        vd_old = {64{8'h99}};
        vs1_data = '1;
        repeat (4) step();
        checks++; if (vd_data !== exp_vd) $display("FAIL idle_hold_vd got=%h exp=%h", vd_data, exp_vd); else passes++;
    endtask

    task automatic test_unknown_vsew();
        vs1_data = '0;
        vs2_data = '0;
        vd_old   = {64{8'h33}};
        exp_vd   = {64{8'h33}};
        for (int i = 0; i < 3; i++) begin
            vs1_data[i*64 +: 64] = 64'h1234_5678_9ABC_DE00 + 64'(i);
            vs2_data[i*64 +: 64] = 64'h0000_0001_0000_0000;
            exp_vd[i*64 +: 64]   = 64'h1234_5679_9ABC_DE00 + 64'(i);
        end
        run_instr(3'd6, 7'd3, 1'b0, 64'h0, 0);
        checks++; if (done_cycle !== 3) $display("FAIL unk_done_cycle got=%0d exp=3", done_cycle); else passes++;
        checks++; if (vd_data !== exp_vd) $display("FAIL unk_vd got=%h exp=%h", vd_data, exp_vd); else passes++;
        step();
    endtask

    task automatic test_reset_mid_issue();
        int done_seen;
        for (int i = 0; i < VSZ; i++) begin
            vs1_data[i*64 +: 64] = 64'(i);
            vs2_data[i*64 +: 64] = 64'd100;
        end
        vd_old   = {64{8'hAA}};
        cur_vsew = 3'd3;
        vl       = 7'd8;
        vm       = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (lane_valid !== 2'b11) $display("FAIL rmid_second_issue got=%b exp=11", lane_valid); else passes++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (ready !== 1'b1) $display("FAIL rmid_ready got=%0b exp=1", ready); else passes++;
        checks++; if (vd_data !== '0) $display("FAIL rmid_vd got=%h exp=0", vd_data); else passes++;
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            if (done === 1'b1) done_seen++;
            step();
        end
        checks++; if (done_seen !== 0) $display("FAIL rmid_no_done got=%0d exp=0", done_seen); else passes++;
        $display("txn reset mid-issue ready=%0b done_pulses=%0d", ready, done_seen);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        cur_vsew = 3'd0;
        vl       = 7'd0;
        vm       = 1'b0;
        vs1_data = '0;
        vs2_data = '0;
        vd_old   = '0;
        v0_mask  = '0;
        exp_vd   = '0;
        test_reset();
        test_eight_byte_add();
        test_one_byte_tail();
        test_masked();
        test_vl_zero();
        test_clamp_ignore_start();
        test_two_byte_hold();
        test_unknown_vsew();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vector_issue_sequencer.md
VECTOR_ISSUE_SEQUENCER -- requirements
Module: vector_issue_sequencer

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): LONGEST_LEN, 64, lane operand width; VECTOR_SIZE, 8, 64-bit words per vector register; LANE_SIZE, 2, number of ALU lanes fed per cycle.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  accept instruction when ready=1
- ready  out  1  idle, able to accept
- cur_vsew  in  3  element width code (ONE/TWO/FOUR/EIGHT_BYTE)
- vl  in  7  active element count
- vm  in  1  mask-enable bit from instruction
- vs1_data, vs2_data, vd_old  in  VECTOR_SIZE*LONGEST_LEN  packed source/old-destination registers
- v0_mask  in  64  mask bits, bit i for element i
- lane_valid  out  LANE_SIZE  lane k holds a real element
- lane_vs1, lane_vs2  out  LANE_SIZE*LONGEST_LEN  zero-extended element operands per lane
- lane_mask  out  LANE_SIZE  v0 bit of the element in lane k
- lane_vm  out  1  registered vm
- lane_result  in  LANE_SIZE*LONGEST_LEN  combinational lane results; low SEW bits used
- vd_data  out  VECTOR_SIZE*LONGEST_LEN  assembled destination register
- done  out  1  one-cycle pulse; vd_data valid

Function
REQ-003 States SHALL be IDLE, ISSUE, DONE; ready=1 only in IDLE.
REQ-004 In IDLE, start=1 SHALL capture cur_vsew, vm, vs1_data, vs2_data, v0_mask; load vd_data from vd_old; clear the element index; then enter ISSUE, or DONE if effective vl=0.
REQ-005 start while not IDLE SHALL be ignored.
REQ-006 SEW = 8/16/32/64 per cur_vsew; VLMAX = VECTOR_SIZE*64/SEW; effective vl = min(vl, VLMAX).
REQ-007 In ISSUE, element index i = base+k SHALL drive lane k. Operands are bits [i*SEW +: SEW] of vs1/vs2, zero-extended to 64; lane_mask[k] = v0_mask[i]; lane_valid[k] = (i < effective vl).
REQ-008 At each ISSUE clock edge, for each lane with lane_valid=1 and (lane_mask=1 or vm=0), the low SEW bits of lane_result SHALL be written into vd_data[i*SEW +: SEW]. All other element slots SHALL keep their vd_old value (mask- and tail-undisturbed).
REQ-009 base SHALL advance by LANE_SIZE per ISSUE cycle. When base+LANE_SIZE >= effective vl, the FSM SHALL go to DONE. ISSUE therefore lasts ceil(effective vl / LANE_SIZE) cycles.
REQ-010 DONE SHALL assert done=1 for exactly one cycle, hold vd_data stable, and return to IDLE.
REQ-011 vd_data SHALL hold its value in IDLE until the next accepted start.
REQ-012 Outside ISSUE, lane_valid SHALL be 0 and lane_vs1/lane_vs2/lane_mask SHALL be 0.
REQ-013 An unrecognised cur_vsew SHALL be treated as EIGHT_BYTE.

Reset
REQ-014 With rst=1 at a clock edge, the FSM SHALL go to IDLE; ready=1; done=0; lane_valid=0; vd_data=0; index=0. Rst takes priority over start.
REQ-015 Reset mid-ISSUE SHALL abandon the instruction without a done pulse.

Structure
REQ-016 VSEW codes (ONE/TWO/FOUR/EIGHT_BYTE) and the state encoding SHALL live in the shared defines file.
REQ-017 The datapath SHALL be a single module. The per-lane operand slicer (index, SEW -> 64-bit zero-extended element) is the one natural sub-module: vector_elem_slicer.

Verification
REQ-018 vsew=EIGHT_BYTE, vl=8, vm=0, lanes adding, vs1[i]=i, vs2[i]=100 -> 4 ISSUE cycles; done in cycle 5; vd element i = 100+i.
REQ-019 vsew=ONE_BYTE, vl=5, vd_old all 0xFF, vs1=vs2=1 -> bytes 0..4 = 0x02, bytes 5..63 = 0xFF; lane_valid[1]=0 in the 3rd ISSUE cycle.
REQ-020 vsew=FOUR_BYTE, vl=4, vm=1, v0_mask=4'b0101 -> only elements 0 and 2 updated; elements 1 and 3 equal vd_old.
REQ-021 vl=0 -> done on the cycle after start with no ISSUE cycle; vd_data = vd_old.
REQ-022 vsew=ONE_BYTE, vl=100 -> clamped to 64; 32 ISSUE cycles; a start pulse mid-ISSUE is ignored.
REQ-023 rst asserted in the 2nd ISSUE cycle -> next cycle ready=1, vd_data=0, no done pulse.
